// File: rtl/pipeline_hazard_controller.sv
// Front-end sequencer: fetch/decode enable, stall and flush control for an RV32I core.
// Latency: control outputs are combinational from state and inputs; state and counters update on the next clk edge.
// Backpressure: imem_valid=0 holds the PC and flushes decode; a load-use hazard holds the PC and decode for one cycle.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   run                  core run enable
//   imem_valid           instruction memory data valid for the current fetch
//   id_rs1/id_rs2        decode source registers, qualified by id_uses_rs1/id_uses_rs2
//   ex_rd, ex_mem_read   execute destination register and load flag
//   ex_branch_taken      redirect resolved in execute this cycle
//   imem_req             fetch request
//   fetch_enable/pc_hold PC advance/load or hold
//   decode_enable/decode_stall_control/decode_flush  IF/ID register capture, hold or NOP
//   ex_bubble            ID/EX register loads NOP
//   ctrl_state           IDLE=0, RUN=1, IMEM_WAIT=2, FLUSH=3
//   stall_count          saturating count of cycles with pc_hold=1
module pipeline_hazard_controller #(
  parameter int REG_ADDR_W   = 5,
  parameter int FLUSH_CYCLES = 1,
  parameter int PERF_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  input  logic                  imem_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_branch_taken,
  output logic                  imem_req,
  output logic                  fetch_enable,
  output logic                  pc_hold,
  output logic                  decode_enable,
  output logic                  decode_stall_control,
  output logic                  decode_flush,
  output logic                  ex_bubble,
  output logic [1:0]            ctrl_state,
  output logic [PERF_W-1:0]     stall_count
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    IMEM_WAIT = 2'd2,
    FLUSH     = 2'd3
  } state_e;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

  state_e              state_q, state_d;
  logic [2:0]          flush_cnt_q, flush_cnt_d;
  logic [PERF_W-1:0]   stall_cnt_q;
  logic                hazard;

  // x0 is hardwired zero, so a load targeting it never creates a dependency.
  assign hazard = ex_mem_read && (ex_rd != '0) &&
                  ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                   (id_uses_rs2 && (id_rs2 == ex_rd)));

  always_comb begin
    imem_req             = 1'b0;
    fetch_enable         = 1'b0;
    pc_hold              = 1'b0;
    decode_enable        = 1'b0;
    decode_stall_control = 1'b0;
    decode_flush         = 1'b0;
    ex_bubble            = 1'b0;
    state_d              = state_q;
    flush_cnt_d          = flush_cnt_q;

    case (state_q)
      IDLE: begin
        if (run) state_d = RUN;
      end

      RUN, IMEM_WAIT: begin
        imem_req = 1'b1;
        // Priority: redirect > fetch miss > load-use > normal advance.
        if (ex_branch_taken) begin
          fetch_enable = 1'b1;
          decode_flush = 1'b1;
          ex_bubble    = 1'b1;
          if (FLUSH_CYCLES == 0) begin
            state_d = RUN;
          end else begin
            state_d     = FLUSH;
            flush_cnt_d = FLUSH_LOAD;
          end
        end else if (!imem_valid) begin
          // Instruction already in decode still moves on to EX.
          pc_hold      = 1'b1;
          decode_flush = 1'b1;
          state_d      = IMEM_WAIT;
        end else if (hazard) begin
          // One bubble is enough: it clears ex_mem_read next cycle.
          pc_hold              = 1'b1;
          decode_stall_control = 1'b1;
          ex_bubble            = 1'b1;
          state_d              = RUN;
        end else begin
          fetch_enable  = 1'b1;
          decode_enable = 1'b1;
          state_d       = RUN;
        end
        if (!run) begin
          state_d     = IDLE;
          flush_cnt_d = '0;
        end
      end

      FLUSH: begin
        imem_req     = 1'b1;
        decode_flush = 1'b1;
        ex_bubble    = 1'b1;
        if (ex_branch_taken) begin
          // A new redirect restarts the wrong-path squash window.
          fetch_enable = 1'b1;
          flush_cnt_d  = FLUSH_LOAD;
        end else begin
          fetch_enable = imem_valid;
          pc_hold      = !imem_valid;
          if (flush_cnt_q <= 3'd1) begin
            flush_cnt_d = '0;
            state_d     = run ? RUN : IDLE;
          end else begin
            flush_cnt_d = flush_cnt_q - 3'd1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      flush_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      if (pc_hold && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + PERF_W'(1);
    end
  end

  assign ctrl_state  = state_q;
  assign stall_count = stall_cnt_q;

  a_fetch_hold_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(fetch_enable && pc_hold));
  a_decode_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0({decode_enable, decode_stall_control, decode_flush}));
  a_run_fetch_or_hold: assert property (@(posedge clk) disable iff (!rst_n)
    ((state_q == RUN) || (state_q == IMEM_WAIT)) |-> (fetch_enable ^ pc_hold));

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Central sequencer for the RV32I front end (fetch and decode stages). Drives the fetch/decode enable, stall and flush controls.
- Detects load-use hazards between ID and EX.
- Absorbs instruction-memory wait states.
- Flushes wrong-path instructions after a taken branch or jump resolved in EX.
- Sits between the instruction memory handshake, the decode/execute stage registers and the branch unit.

Parameters:
REG_ADDR_W, 5, register index width
FLUSH_CYCLES, 1, extra flush cycles after the resolve cycle (legal range 0..7)
PERF_W, 16, width of the stall performance counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
run  in  1  core run enable
imem_valid  in  1  instruction memory data valid for the current fetch
id_rs1  in  REG_ADDR_W  rs1 of instruction in decode
id_rs2  in  REG_ADDR_W  rs2 of instruction in decode
id_uses_rs1  in  1  decode instruction reads rs1
id_uses_rs2  in  1  decode instruction reads rs2
ex_rd  in  REG_ADDR_W  destination of instruction in execute
ex_mem_read  in  1  execute instruction is a load
ex_branch_taken  in  1  branch/jump redirect resolved this cycle
imem_req  out  1  fetch request
fetch_enable  out  1  PC advances/loads
pc_hold  out  1  PC holds value
decode_enable  out  1  decode register captures fetched instruction
decode_stall_control  out  1  decode register holds
decode_flush  out  1  decode register loads NOP
ex_bubble  out  1  ID/EX register loads NOP
ctrl_state  out  2  IDLE=0, RUN=1, IMEM_WAIT=2, FLUSH=3
stall_count  out  PERF_W  cycles with pc_hold=1, saturating

Behaviour:
- Reset (rst_n=0, asynchronous): ctrl_state=IDLE, flush counter=0, stall_count=0, all outputs 0. Deassertion is synchronised by the integrator.
- Outputs are combinational from state and inputs (same-cycle hazard response). State and counters update on posedge clk.
- hazard = ex_mem_read & (ex_rd!=0) & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- IDLE:
  - All outputs 0.
  - run=1 -> RUN.
- RUN and IMEM_WAIT: imem_req=1. Priority is branch > imem miss > hazard > normal.
  - ex_branch_taken:
    - fetch_enable=1, decode_flush=1, ex_bubble=1.
    - Next state FLUSH with counter=FLUSH_CYCLES; if FLUSH_CYCLES=0, next state RUN.
  - !imem_valid:
    - pc_hold=1, decode_flush=1.
    - Next state IMEM_WAIT.
    - The instruction already in decode proceeds to EX normally.
  - hazard:
    - pc_hold=1, decode_stall_control=1, ex_bubble=1.
    - State unchanged (IMEM_WAIT -> RUN).
    - A one-cycle stall is sufficient because the bubble clears ex_mem_read.
  - Normal: fetch_enable=1, decode_enable=1. Next state RUN.
- FLUSH:
  - decode_flush=1, ex_bubble=1, imem_req=1.
  - fetch_enable=imem_valid, pc_hold=!imem_valid.
  - Counter decrements each cycle; counter==1 -> RUN.
  - A further ex_branch_taken reloads the counter and fetch_enable=1.
- run=0 sampled in RUN or IMEM_WAIT: next state IDLE. That cycle's outputs are computed normally.
- run=0 in FLUSH: the flush completes first, then the next state is IDLE if run is still 0.
- Invariants (assert every cycle):
  - fetch_enable and pc_hold are never both 1.
  - decode_enable, decode_stall_control and decode_flush are one-hot-or-zero.
  - In RUN and IMEM_WAIT, exactly one of fetch_enable and pc_hold is 1.
- ex_rd=0 never causes a stall.
- Simultaneous load-use hazard and taken branch: the branch wins; no stall occurs.
- stall_count increments on every cycle with pc_hold=1 and saturates at all-ones (no wrap).
- Reset mid-FLUSH or mid-IMEM_WAIT: immediate IDLE; counters cleared.

Test Plan:
- Reset with run=0, then run=1, imem_valid=1 -> ctrl_state 0 then 1; fetch_enable=1 and decode_enable=1 from the first RUN cycle; stall_count=0.
- ex_mem_read=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 -> exactly one cycle of pc_hold=1, decode_stall_control=1, ex_bubble=1. Repeat with ex_rd=0 or id_uses_rs2=0 -> no stall.
- imem_valid=0 for 3 cycles in RUN -> IMEM_WAIT for 3 cycles with pc_hold=1 and decode_flush=1; fetch_enable=1 in the cycle imem_valid returns; stall_count=3.
- ex_branch_taken=1 with FLUSH_CYCLES=1 -> decode_flush=1 and ex_bubble=1 in the resolve cycle plus 1 FLUSH cycle, then RUN. Rerun with FLUSH_CYCLES=0 -> no FLUSH state.
- Branch and load-use hazard in the same cycle -> flush outputs only; decode_stall_control=0.
- rst_n pulsed low mid-FLUSH and with stall_count=0xFFFF saturated -> outputs 0 and ctrl_state=0 asynchronously; stall_count=0. A saturation run of 70000 stalled cycles holds stall_count at 0xFFFF.
